// File: rtl/rvfi_rv32imc_checker.sv
// Passive RVFI retirement checker for a single-retire RV32IMC core; latches the first violation on errcode.
// Define RVFI_MON_REGCHECK_EN to compile in the shadow register file and its read-back checks.
module rvfi_rv32imc_checker (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rvfi_valid,
    input  logic [63:0] rvfi_order,
    input  logic [31:0] rvfi_insn,
    input  logic        rvfi_trap,
    input  logic        rvfi_halt,
    input  logic        rvfi_intr,
    input  logic [1:0]  rvfi_mode,
    input  logic [4:0]  rvfi_rs1_addr,
    input  logic [4:0]  rvfi_rs2_addr,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [31:0] rvfi_rs1_rdata,
    input  logic [31:0] rvfi_rs2_rdata,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [31:0] rvfi_pc_rdata,
    input  logic [31:0] rvfi_pc_wdata,
    input  logic [31:0] rvfi_mem_addr,
    input  logic [3:0]  rvfi_mem_rmask,
    input  logic [3:0]  rvfi_mem_wmask,
    input  logic [31:0] rvfi_mem_rdata,
    input  logic [31:0] rvfi_mem_wdata,
    input  logic        rvfi_mem_extamo,
    output logic [15:0] errcode
);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned ORDER_W = 64;
    localparam int unsigned ERR_W   = 16;
    localparam int unsigned REG_N   = 32;

    localparam logic [ERR_W-1:0] ERR_NONE     = ERR_W'(0);
    localparam logic [ERR_W-1:0] ERR_ORDER    = ERR_W'(101);
    localparam logic [ERR_W-1:0] ERR_HALT     = ERR_W'(102);
    localparam logic [ERR_W-1:0] ERR_LENGTH   = ERR_W'(103);
    localparam logic [ERR_W-1:0] ERR_PC_ALIGN = ERR_W'(104);
    localparam logic [ERR_W-1:0] ERR_PC_CONT  = ERR_W'(105);
    localparam logic [ERR_W-1:0] ERR_X0_WRITE = ERR_W'(106);
    localparam logic [ERR_W-1:0] ERR_RS1      = ERR_W'(107);
    localparam logic [ERR_W-1:0] ERR_RS2      = ERR_W'(108);
    localparam logic [ERR_W-1:0] ERR_MEM_MASK = ERR_W'(109);
    localparam logic [ERR_W-1:0] ERR_TRAP     = ERR_W'(110);
    localparam logic [ERR_W-1:0] ERR_SEQ_PC   = ERR_W'(111);

    logic               have_base_q;
    logic               halted_q;
    logic [ORDER_W-1:0] prev_order_q;
    logic [XLEN-1:0]    prev_pc_q;

    logic               is_rvc;
    logic               ctrl_flow;
    logic [2:0]         c_funct3;
    logic [XLEN-1:0]    seq_pc;
    logic               mask_err;
    logic               rs1_shadow_bad;
    logic               rs2_shadow_bad;
    logic [ERR_W-1:0]   code_c;

    logic unused_ok;
    assign unused_ok = ^{rvfi_mode, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_extamo, rvfi_insn[12]};

    // Byte-lane masks must be a naturally aligned byte, halfword or word.
    function automatic logic mask_bad(input logic [3:0] m);
        case (m)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: mask_bad = 1'b0;
            default:                   mask_bad = 1'b1;
        endcase
    endfunction

`ifdef RVFI_MON_REGCHECK_EN
    logic [XLEN-1:0]  shadow_q [REG_N];
    logic [REG_N-1:0] shadow_vld_q;

    assign rs1_shadow_bad = shadow_vld_q[rvfi_rs1_addr] && (shadow_q[rvfi_rs1_addr] != rvfi_rs1_rdata);
    assign rs2_shadow_bad = shadow_vld_q[rvfi_rs2_addr] && (shadow_q[rvfi_rs2_addr] != rvfi_rs2_rdata);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_vld_q <= '0;
        end else if (rvfi_valid && rvfi_rd_addr != 5'd0) begin
            shadow_vld_q[rvfi_rd_addr] <= 1'b1;
        end
    end

    // Data needs no reset: entries are only read once their valid bit is set.
    always_ff @(posedge clock) begin
        if (rvfi_valid && rvfi_rd_addr != 5'd0) begin
            shadow_q[rvfi_rd_addr] <= rvfi_rd_wdata;
        end
    end
`else
    assign rs1_shadow_bad = 1'b0;
    assign rs2_shadow_bad = 1'b0;
`endif

    // Per-record violation detection; ascending priority so the lowest code wins.
    always_comb begin
        code_c    = ERR_NONE;
        is_rvc    = rvfi_insn[1:0] != 2'b11;
        c_funct3  = rvfi_insn[15:13];
        ctrl_flow = 1'b0;
        seq_pc    = rvfi_pc_rdata + (is_rvc ? XLEN'(2) : XLEN'(4));
        mask_err  = mask_bad(rvfi_mem_rmask) || mask_bad(rvfi_mem_wmask)
                 || (rvfi_mem_addr[1:0] != 2'b00 && (rvfi_mem_rmask | rvfi_mem_wmask) != 4'b0000);

        if (!is_rvc) begin
            ctrl_flow = rvfi_insn[6:0] inside {7'b1101111, 7'b1100111, 7'b1100011};
        end else if (rvfi_insn[1:0] == 2'b01) begin
            ctrl_flow = c_funct3 inside {3'b001, 3'b101, 3'b110, 3'b111};
        end else if (rvfi_insn[1:0] == 2'b10) begin
            ctrl_flow = (c_funct3 == 3'b100) && (rvfi_insn[11:7] != 5'd0) && (rvfi_insn[6:2] == 5'd0);
        end

        if (have_base_q && rvfi_order != prev_order_q + ORDER_W'(1)) begin
            code_c = ERR_ORDER;
        end else if (halted_q) begin
            code_c = ERR_HALT;
        end else if (is_rvc && rvfi_insn[31:16] != 16'h0000) begin
            code_c = ERR_LENGTH;
        end else if (rvfi_pc_rdata[0] || rvfi_pc_wdata[0]) begin
            code_c = ERR_PC_ALIGN;
        end else if (have_base_q && !rvfi_intr && rvfi_pc_rdata != prev_pc_q) begin
            code_c = ERR_PC_CONT;
        end else if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != '0) begin
            code_c = ERR_X0_WRITE;
        end else if ((rvfi_rs1_addr == 5'd0 && rvfi_rs1_rdata != '0) || rs1_shadow_bad) begin
            code_c = ERR_RS1;
        end else if ((rvfi_rs2_addr == 5'd0 && rvfi_rs2_rdata != '0) || rs2_shadow_bad) begin
            code_c = ERR_RS2;
        end else if (mask_err) begin
            code_c = ERR_MEM_MASK;
        end else if (rvfi_trap) begin
            code_c = ERR_TRAP;
        end else if (!ctrl_flow && rvfi_pc_wdata != seq_pc) begin
            code_c = ERR_SEQ_PC;
        end
    end

    // Trace history and sticky first-error register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            have_base_q  <= 1'b0;
            halted_q     <= 1'b0;
            prev_order_q <= '0;
            prev_pc_q    <= '0;
            errcode      <= ERR_NONE;
        end else if (rvfi_valid) begin
            have_base_q  <= 1'b1;
            prev_order_q <= rvfi_order;
            prev_pc_q    <= rvfi_pc_wdata;
            if (rvfi_halt) begin
                halted_q <= 1'b1;
            end
            if (errcode == ERR_NONE) begin
                errcode <= code_c;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_rv32imc_checker.sv
// Scoreboard bench for rvfi_rv32imc_checker: directed trace scenarios plus randomized traces with injected faults.
module tb_rvfi_rv32imc_checker;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap, rvfi_halt, rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic [31:0] rvfi_mem_rdata, rvfi_mem_wdata;
    logic        rvfi_mem_extamo;
    logic [15:0] errcode;

    rvfi_rv32imc_checker dut (
        .clock(clock), .reset_n(reset_n), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_mem_extamo(rvfi_mem_extamo), .errcode(errcode)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];

    // Reference model state: history of the trace as seen since the last reset.
    bit          m_have;
    bit          m_halted;
    logic [63:0] m_order;
    logic [31:0] m_pc;
    logic [15:0] m_err;
    logic [31:0] m_regs[int];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: errcode=%0d expected %0d", name, act, exp);
    endtask

    // Monitor: one expected errcode per clock edge, compared just after the edge.
    always @(posedge clock) begin
        cyc++;
        #1;
        if (exp_q.size() > 0) check($sformatf("errcode_cyc%0d", cyc), errcode, exp_q.pop_front());
    end

    function automatic bit mask_ok(input logic [3:0] m);
        logic [3:0] legal[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        foreach (legal[i]) if (legal[i] == m) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_ctrl(input logic [31:0] insn);
        logic [2:0] f3 = insn[15:13];
        if (insn[1:0] == 2'b11) return insn[6:0] == 7'h6F || insn[6:0] == 7'h67 || insn[6:0] == 7'h63;
        if (insn[1:0] == 2'b01) return f3 == 3'd1 || f3 == 3'd5 || f3 == 3'd6 || f3 == 3'd7;
        if (insn[1:0] == 2'b10) return f3 == 3'd4 && insn[11:7] != 5'd0 && insn[6:2] == 5'd0;
        return 1'b0;
    endfunction

    function automatic bit read_bad(input logic [4:0] a, input logic [31:0] d);
        if (a == 5'd0) return d != 32'd0;
`ifdef RVFI_MON_REGCHECK_EN
        if (m_regs.exists(int'(a))) return m_regs[int'(a)] != d;
`endif
        return 1'b0;
    endfunction

    // All violated rules for the current record; the smallest one is reported.
    function automatic logic [15:0] model_code();
        int codes[$];
        int best;
        logic [31:0] len = (rvfi_insn[1:0] == 2'b11) ? 32'd4 : 32'd2;
        if (m_have && rvfi_order != m_order + 64'd1) codes.push_back(101);
        if (m_halted) codes.push_back(102);
        if (rvfi_insn[1:0] != 2'b11 && rvfi_insn[31:16] != 16'd0) codes.push_back(103);
        if (rvfi_pc_rdata[0] || rvfi_pc_wdata[0]) codes.push_back(104);
        if (m_have && !rvfi_intr && rvfi_pc_rdata != m_pc) codes.push_back(105);
        if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != 32'd0) codes.push_back(106);
        if (read_bad(rvfi_rs1_addr, rvfi_rs1_rdata)) codes.push_back(107);
        if (read_bad(rvfi_rs2_addr, rvfi_rs2_rdata)) codes.push_back(108);
        if (!mask_ok(rvfi_mem_rmask) || !mask_ok(rvfi_mem_wmask) ||
            ((rvfi_mem_rmask | rvfi_mem_wmask) != 4'd0 && rvfi_mem_addr[1:0] != 2'd0)) codes.push_back(109);
        if (rvfi_trap) codes.push_back(110);
        if (!is_ctrl(rvfi_insn) && rvfi_pc_wdata != rvfi_pc_rdata + len) codes.push_back(111);
        best = 0;
        foreach (codes[i]) if (best == 0 || codes[i] < best) best = codes[i];
        return 16'(best);
    endfunction

    task automatic model_commit();
        if (m_err == 16'd0) m_err = model_code();
        if (rvfi_rd_addr != 5'd0) m_regs[int'(rvfi_rd_addr)] = rvfi_rd_wdata;
        m_have  = 1'b1;
        m_order = rvfi_order;
        m_pc    = rvfi_pc_wdata;
        if (rvfi_halt) m_halted = 1'b1;
    endtask

    task automatic send();
        rvfi_valid = 1'b1;
        model_commit();
        exp_q.push_back(m_err);
        @(negedge clock);
        rvfi_valid = 1'b0;
    endtask

    // Idle cycle carrying junk fields that must be ignored.
    task automatic idle();
        rvfi_valid = 1'b0;
        rvfi_order = {$urandom(), $urandom()};
        rvfi_halt  = 1'($urandom_range(0, 1));
        rvfi_trap  = 1'($urandom_range(0, 1));
        rvfi_rd_addr = 5'd0;
        rvfi_rd_wdata = $urandom();
        exp_q.push_back(m_err);
        @(negedge clock);
    endtask

    task automatic do_reset();
        rvfi_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_reset", errcode, 16'd0);
        m_have = 1'b0; m_halted = 1'b0; m_order = '0; m_pc = '0; m_err = 16'd0;
        m_regs.delete();
        @(negedge clock);
        idle();
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] reg_val(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_regs.exists(int'(a))) return m_regs[int'(a)];
        return $urandom();
    endfunction

    // A well-formed addi record continuing the current trace.
    task automatic base_record();
        rvfi_order     = m_have ? m_order + 64'd1 : 64'd0;
        rvfi_pc_rdata  = m_have ? m_pc : 32'd0;
        rvfi_pc_wdata  = rvfi_pc_rdata + 32'd4;
        rvfi_insn      = 32'h0000_0013;
        rvfi_trap = 1'b0; rvfi_halt = 1'b0; rvfi_intr = 1'b0;
        rvfi_mode = 2'd3; rvfi_mem_extamo = 1'b0;
        rvfi_rs1_addr = 5'd0; rvfi_rs2_addr = 5'd0; rvfi_rd_addr = 5'd0;
        rvfi_rs1_rdata = 32'd0; rvfi_rs2_rdata = 32'd0; rvfi_rd_wdata = 32'd0;
        rvfi_mem_addr = 32'd0; rvfi_mem_rmask = 4'd0; rvfi_mem_wmask = 4'd0;
        rvfi_mem_rdata = $urandom(); rvfi_mem_wdata = $urandom();
    endtask

    task automatic rand_record();
        logic [31:0] r = $urandom();
        logic [3:0]  legal[7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        base_record();
        if ($urandom_range(0, 15) == 0) begin
            rvfi_intr = 1'b1;
            rvfi_pc_rdata = {r[31:2], 2'b00};
            rvfi_pc_wdata = rvfi_pc_rdata + 32'd4;
        end
        rvfi_rs1_addr = 5'($urandom_range(0, 31));
        rvfi_rs2_addr = 5'($urandom_range(0, 31));
        rvfi_rd_addr  = 5'($urandom_range(0, 31));
        rvfi_rs1_rdata = reg_val(rvfi_rs1_addr);
        rvfi_rs2_rdata = reg_val(rvfi_rs2_addr);
        rvfi_rd_wdata  = (rvfi_rd_addr == 5'd0) ? 32'd0 : $urandom();
        case ($urandom_range(0, 5))
            0: rvfi_insn = {r[31:20], rvfi_rs1_addr, 3'b000, rvfi_rd_addr, 7'b0010011};
            1: begin
                rvfi_insn = {16'h0, 3'b000, r[12], rvfi_rd_addr, r[6:2], 2'b01};
                rvfi_pc_wdata = rvfi_pc_rdata + 32'd2;
            end
            2: begin
                rvfi_insn = {r[31:25], rvfi_rs2_addr, rvfi_rs1_addr, 3'b000, 5'd0, 7'b1100011};
                if (r[0]) rvfi_insn[6:0] = 7'b1101111;
                rvfi_pc_wdata = {r[31:2], 2'b00};
            end
            3: begin
                rvfi_insn = {16'h0, 3'b101, r[12:2], 2'b01};
                rvfi_pc_wdata = {r[30:1], 2'b10};
            end
            4: begin
                rvfi_insn = {16'h0, 3'b100, r[12], 5'd7, r[6:2], 2'b10};
                rvfi_pc_wdata = (r[6:2] == 5'd0) ? {r[31:2], 2'b00} : rvfi_pc_rdata + 32'd2;
            end
            default: begin
                rvfi_insn = {r[31:20], rvfi_rs1_addr, 3'b010, rvfi_rd_addr, 7'b0000011};
                rvfi_mem_addr = {r[31:2], 2'b00};
                if (r[1]) rvfi_mem_rmask = legal[$urandom_range(0, 6)];
                else      rvfi_mem_wmask = legal[$urandom_range(0, 6)];
            end
        endcase
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 11))
                0:  rvfi_order = rvfi_order + 64'd2;
                1:  rvfi_pc_rdata = rvfi_pc_rdata ^ 32'd4;
                2:  begin rvfi_rd_addr = 5'd0; rvfi_rd_wdata = $urandom() | 32'd1; end
                3:  rvfi_rs1_rdata = rvfi_rs1_rdata ^ 32'd1;
                4:  rvfi_rs2_rdata = rvfi_rs2_rdata ^ 32'h8000_0000;
                5:  rvfi_mem_wmask = 4'($urandom_range(0, 15));
                6:  begin rvfi_mem_addr = rvfi_mem_addr | 32'd2; rvfi_mem_rmask = 4'b0001; end
                7:  rvfi_trap = 1'b1;
                8:  rvfi_pc_wdata = rvfi_pc_wdata + 32'd8;
                9:  rvfi_insn = {16'h1234, 16'h0505};
                10: rvfi_halt = 1'b1;
                default: rvfi_pc_wdata = rvfi_pc_wdata | 32'd1;
            endcase
        end
        send();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        base_record();
        rvfi_valid = 1'b0;
        m_err = 16'd0;
        @(negedge clock);
        check("reset_value", errcode, 16'd0);
        do_reset();

        // Three clean addi records.
        for (int i = 0; i < 3; i++) begin
            base_record();
            rvfi_rd_addr = 5'd1; rvfi_rd_wdata = 32'(i);
            rvfi_insn = {12'(i), 5'd0, 3'b000, 5'd1, 7'b0010011};
            send();
        end
        idle();

        // Order gap, then a trap that must not overwrite the sticky code.
        do_reset();
        base_record(); rvfi_order = 64'd5; send();
        base_record(); rvfi_order = 64'd7; send();
        base_record(); rvfi_trap = 1'b1; send();
        idle();

        // Shadow register read-back mismatch on x5.
        do_reset();
        base_record(); rvfi_rd_addr = 5'd5; rvfi_rd_wdata = 32'h1234; send();
        base_record(); rvfi_rs1_addr = 5'd5; rvfi_rs1_rdata = 32'h1235; send();
        idle();

        // c.addi with wrong and correct next PC.
        do_reset();
        base_record(); rvfi_pc_rdata = 32'h100; rvfi_pc_wdata = 32'h104;
        rvfi_insn = 32'h0000_0505; send();
        do_reset();
        base_record(); rvfi_pc_rdata = 32'h100; rvfi_pc_wdata = 32'h102;
        rvfi_insn = 32'h0000_0505; send();
        idle();

        // Illegal store mask.
        do_reset();
        base_record(); rvfi_insn = 32'h0000_2023; rvfi_mem_wmask = 4'b0101; send();

        // PC discontinuity outranks the x0 write.
        do_reset();
        base_record(); send();
        base_record(); rvfi_rd_addr = 5'd0; rvfi_rd_wdata = 32'd1;
        rvfi_pc_rdata = 32'h40; rvfi_pc_wdata = 32'h44; send();

        // Retire after halt, then reset gives a fresh baseline.
        do_reset();
        base_record(); rvfi_halt = 1'b1; send();
        base_record(); send();
        idle();
        do_reset();
        base_record(); rvfi_order = 64'h99; rvfi_pc_rdata = 32'h2000; rvfi_pc_wdata = 32'h2004; send();
        base_record(); send();
        idle();

        // Randomized traces, each starting from reset.
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int k = 0; k < 25; k++) begin
                rand_record();
                if ($urandom_range(0, 5) == 0) idle();
            end
        end

        idle();
        idle();
        #2;
        if (exp_q.size() != 0) check("scoreboard_drain", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
